reg_file_sb: RTL and testbench

Parametrised second-generation register file for the datapath: two write ports, two asynchronous read ports and a per-register pending (scoreboard) bit. It adds synchronous reset, an optional hardwired-zero register and a sequenced bulk-clear engine. It replaces the single-write 16x8 register file between decode (issue and read) and the ALU/load writeback stages.

---
 rtl/reg_file_sb.sv | 120 ++++++++++++
 tb/tb_reg_file_sb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Dual-write, dual-read register file with per-register pending bits and a sequenced bulk-clear engine.
// Optional write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEnA,
    input  logic [ADDR_W-1:0] wAddA,
    input  logic [DATA_W-1:0] wDataA,
    input  logic              wrEnB,
    input  logic [ADDR_W-1:0] wAddB,
    input  logic [DATA_W-1:0] wDataB,
    input  logic [ADDR_W-1:0] rAddA,
    input  logic [ADDR_W-1:0] rAddB,
    output logic [DATA_W-1:0] rDataA,
    output logic [DATA_W-1:0] rDataB,
    output logic              busyA,
    output logic              busyB,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueAdd,
    input  logic              clrReq,
    output logic              clrBusy,
    output logic              clrDone
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W-1:0] cnt;
    logic              clr_busy;
    logic              clr_done_q;
    logic              clr_last;
    logic              en_a, en_b, en_i;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign clr_last = (state == CLEAR) && (cnt == ADDR_W'(DEPTH-1));
    assign en_a = wrEnA   && !clr_busy && !is_zero(wAddA);
    assign en_b = wrEnB   && !clr_busy && !is_zero(wAddB);
    assign en_i = issueEn && !clr_busy && !is_zero(issueAdd);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clrReq)   state_nxt = CLEAR;
            CLEAR:   if (clr_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr_busy = (state == CLEAR);
    end

    assign clrBusy = clr_busy;
    assign clrDone = clr_done_q;

    // Counter only runs in CLEAR, so it naturally wraps to 0 on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            clr_done_q <= 1'b0;
        end else begin
            cnt        <= clr_busy ? cnt + 1'b1 : '0;
            clr_done_q <= clr_last;
        end
    end

    // Port A is written after port B so it wins on a shared address; issue is last so a new producer wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else if (clr_busy) begin
            regs[cnt] <= '0;
            busy[cnt] <= 1'b0;
        end else begin
            if (en_b) regs[wAddB] <= wDataB;
            if (en_a) regs[wAddA] <= wDataA;
            if (en_b) busy[wAddB] <= 1'b0;
            if (en_a) busy[wAddA] <= 1'b0;
            if (en_i) busy[issueAdd] <= 1'b1;
        end
    end

    always_comb begin
        rDataA = regs[rAddA];
`ifdef REGFILE_BYPASS_EN
        if (en_a && (wAddA == rAddA))      rDataA = wDataA;
        else if (en_b && (wAddB == rAddA)) rDataA = wDataB;
`endif
        if (is_zero(rAddA)) rDataA = '0;
    end

    always_comb begin
        rDataB = regs[rAddB];
`ifdef REGFILE_BYPASS_EN
        if (en_a && (wAddA == rAddB))      rDataB = wDataA;
        else if (en_b && (wAddB == rAddB)) rDataB = wDataB;
`endif
        if (is_zero(rAddB)) rDataB = '0;
    end

    assign busyA = busy[rAddA] && !is_zero(rAddA);
    assign busyB = busy[rAddB] && !is_zero(rAddB);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: table-driven read/write/issue vectors plus clear and reset sequences.
module tb_reg_file_sb;
    logic       clk = 1'b0;
    logic       reset;
    logic       wrEnA, wrEnB, issueEn, clrReq;
    logic [3:0] wAddA, wAddB, rAddA, rAddB, issueAdd;
    logic [7:0] wDataA, wDataB;
    logic [7:0] rDataA, rDataB, zrDataA, zrDataB;
    logic       busyA, busyB, clrBusy, clrDone;
    logic       zbusyA, zbusyB, zclrBusy, zclrDone;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(0)) dut (
        .clk(clk), .reset(reset),
        .wrEnA(wrEnA), .wAddA(wAddA), .wDataA(wDataA),
        .wrEnB(wrEnB), .wAddB(wAddB), .wDataB(wDataB),
        .rAddA(rAddA), .rAddB(rAddB), .rDataA(rDataA), .rDataB(rDataB),
        .busyA(busyA), .busyB(busyB),
        .issueEn(issueEn), .issueAdd(issueAdd),
        .clrReq(clrReq), .clrBusy(clrBusy), .clrDone(clrDone)
    );

    reg_file_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1)) dutz (
        .clk(clk), .reset(reset),
        .wrEnA(wrEnA), .wAddA(wAddA), .wDataA(wDataA),
        .wrEnB(wrEnB), .wAddB(wAddB), .wDataB(wDataB),
        .rAddA(rAddA), .rAddB(rAddB), .rDataA(zrDataA), .rDataB(zrDataB),
        .busyA(zbusyA), .busyB(zbusyB),
        .issueEn(issueEn), .issueAdd(issueAdd),
        .clrReq(clrReq), .clrBusy(zclrBusy), .clrDone(zclrDone)
    );

    typedef struct {
        logic       wa;
        logic [3:0] aa;
        logic [7:0] da;
        logic       wb;
        logic [3:0] ab;
        logic [7:0] db;
        logic       is;
        logic [3:0] ia;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ba;
        logic       bb;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wrEnA = 1'b0; wrEnB = 1'b0; issueEn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cyc, done_cnt, done_at;
        logic [7:0] exp_same;

        vecs[0] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 4'd15, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd3, 4'd0,  8'h5A, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'd7, 8'h11, 1'b1, 4'd7, 8'h22, 1'b0, 4'd0, 4'd7, 4'd7,  8'h11, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'd9, 8'h44, 1'b1, 4'd8, 8'h33, 1'b0, 4'd0, 4'd9, 4'd8,  8'h44, 8'h33, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 4'd5, 4'd3,  8'h00, 8'h5A, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'd5, 8'h77, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd5, 4'd9,  8'h77, 8'h44, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 8'h66, 1'b1, 4'd6, 4'd6, 4'd5,  8'h66, 8'h77, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 8'h99, 1'b1, 4'd1, 4'd6, 4'd1,  8'h99, 8'h00, 1'b0, 1'b1};

        reset = 1'b1; clrReq = 1'b0; idle_inputs();
        wAddA = '0; wAddB = '0; wDataA = '0; wDataB = '0; issueAdd = '0;
        rAddA = 4'd3; rAddB = 4'd12;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset rDataA", rDataA, 8'h00);
        check("reset busyB", busyB, 1'b0);
        check("reset clrBusy", clrBusy, 1'b0);
        check("reset clrDone", clrDone, 1'b0);

        // Same-cycle visibility of a write: stored value until the edge unless forwarded.
        @(negedge clk);
        wrEnA = 1'b1; wAddA = 4'd3; wDataA = 8'h5A; rAddA = 4'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 8'h5A;
`else
        exp_same = 8'h00;
`endif
        check("write-cycle rDataA", rDataA, exp_same);
        @(posedge clk); #1 idle_inputs(); #1;
        check("post-write rDataA", rDataA, 8'h5A);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wrEnA = vecs[i].wa; wAddA = vecs[i].aa; wDataA = vecs[i].da;
            wrEnB = vecs[i].wb; wAddB = vecs[i].ab; wDataB = vecs[i].db;
            issueEn = vecs[i].is; issueAdd = vecs[i].ia;
            rAddA = vecs[i].ra; rAddB = vecs[i].rb;
            @(posedge clk); #1 idle_inputs(); #1;
            check($sformatf("v%0d rDataA", i), rDataA, vecs[i].ea);
            check($sformatf("v%0d rDataB", i), rDataB, vecs[i].eb);
            check($sformatf("v%0d busyA", i), busyA, vecs[i].ba);
            check($sformatf("v%0d busyB", i), busyB, vecs[i].bb);
        end

        // Address 0: hardwired in dutz, ordinary in dut.
        @(negedge clk);
        wrEnA = 1'b1; wAddA = 4'd0; wDataA = 8'hFF; issueEn = 1'b1; issueAdd = 4'd0; rAddA = 4'd0;
        @(posedge clk); #1 idle_inputs(); #1;
        check("zero-reg rDataA", zrDataA, 8'h00);
        check("zero-reg busyA", zbusyA, 1'b0);
        check("plain r0 rDataA", rDataA, 8'hFF);
        check("plain r0 busyA", busyA, 1'b1);

        // Fill all 16 registers, r(i) = 0x10 + i.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wrEnA = 1'b1; wAddA = 4'(2*i);   wDataA = 8'(8'h10 + 2*i);
            wrEnB = 1'b1; wAddB = 4'(2*i+1); wDataB = 8'(8'h11 + 2*i);
        end
        issueEn = 1'b1; issueAdd = 4'd11;
        @(posedge clk); #1 idle_inputs();
        @(negedge clk); rAddA = 4'd11;
        #1 check("pre-clear busy r11", busyA, 1'b1);

        clrReq = 1'b1;
        @(posedge clk); #1 clrReq = 1'b0; #1;
        busy_cyc = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < 24; c++) begin
            if (clrBusy) busy_cyc++;
            if (clrDone) begin done_cnt++; done_at = c; end
            if (c == 5) begin wrEnA = 1'b1; wAddA = 4'd2; wDataA = 8'hEE; end
            if (c == 6) wrEnA = 1'b0;
            if (c == 8) begin
                rAddA = 4'd3; rAddB = 4'd10; #1;
                check("partial clear r3", rDataA, 8'h00);
                check("partial clear r10", rDataB, 8'h1A);
            end
            @(posedge clk); #2;
        end
        check("clrBusy cycles", busy_cyc, 16);
        check("clrDone pulses", done_cnt, 1);
        check("clrDone cycle", done_at, 16);
        for (int a = 0; a < 16; a++) begin
            rAddA = 4'(a); #1;
            check($sformatf("cleared r%0d data", a), rDataA, 8'h00);
            check($sformatf("cleared r%0d busy", a), busyA, 1'b0);
        end

        // Reset in the middle of a clear.
        @(negedge clk);
        wrEnA = 1'b1; wAddA = 4'd12; wDataA = 8'hC5;
        @(posedge clk); #1 idle_inputs();
        @(negedge clk); clrReq = 1'b1;
        @(posedge clk); #1 clrReq = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        rAddA = 4'd12; #1;
        check("abort clrBusy", clrBusy, 1'b0);
        check("abort clrDone", clrDone, 1'b0);
        check("abort r12", rDataA, 8'h00);
        wrEnA = 1'b1; wAddA = 4'd4; wDataA = 8'h3C; rAddA = 4'd4;
        @(posedge clk); #1 idle_inputs(); #1;
        check("abort no clrDone", clrDone, 1'b0);
        check("post-abort write r4", rDataA, 8'h3C);
        check("post-abort clrBusy", clrBusy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
